// File: rtl/axi_pkg.sv
// Shared AXI4 encodings and the burst-master state enum.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [2:0] SIZE_4B = 3'b010;

    localparam int unsigned LEN_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_AR,
        ST_R,
        ST_DONE
    } state_t;

endpackage

// File: rtl/axi_beat_counter.sv
// Remaining-beat counter shared by the write and read data phases.
module axi_beat_counter
    import axi_pkg::*;
#(
    parameter int unsigned WIDTH = LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             is_last
);

    logic [WIDTH-1:0] cnt;

    // Saturates at zero so a full 256-beat burst never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign is_last = (cnt == '0);

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator with write/read data streams.
module axi_burst_master
    import axi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [3:0]  AXI_ID     = 4'b0000
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,

    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,

    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_valid,
    input  logic                      rd_ready,
    output logic                      rd_last,

    output logic                      done,
    output logic                      err,

    output logic [3:0]                m_axi_awid,
    output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [7:0]                m_axi_awlen,
    output logic [2:0]                m_axi_awsize,
    output logic [1:0]                m_axi_awburst,
    output logic                      m_axi_awvalid,
    input  logic                      m_axi_awready,

    output logic [DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                      m_axi_wlast,
    output logic                      m_axi_wvalid,
    input  logic                      m_axi_wready,

    input  logic [3:0]                m_axi_bid,
    input  logic [1:0]                m_axi_bresp,
    input  logic                      m_axi_bvalid,
    output logic                      m_axi_bready,

    output logic [3:0]                m_axi_arid,
    output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,

    input  logic [3:0]                m_axi_rid,
    input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready
);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic                  cnt_load, cnt_dec, is_last;
    logic                  err_set, err_clr;

    // Response IDs are not checked: only one ID is ever in flight.
    logic                  id_unused;
    assign id_unused = ^{m_axi_bid, m_axi_rid};

    axi_beat_counter #(.WIDTH(LEN_W)) u_beat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cmd_len),
        .dec      (cnt_dec),
        .is_last  (is_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Burst address/length held for the whole address phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
        end else if (cnt_load) begin
            addr_q <= cmd_addr;
            len_q  <= cmd_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (err_clr) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end
    end

    assign m_axi_awid    = AXI_ID;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awsize  = SIZE_4B;
    assign m_axi_awburst = BURST_INCR;
    assign m_axi_arid    = AXI_ID;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = SIZE_4B;
    assign m_axi_arburst = BURST_INCR;

    // Handshake outputs decode from state so reset drops them immediately.
    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        cnt_load      = 1'b0;
        cnt_dec       = 1'b0;
        err_set       = 1'b0;
        err_clr       = 1'b0;
        done          = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wstrb   = '0;
        m_axi_wlast   = 1'b0;
        wr_ready      = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_rready  = 1'b0;
        rd_valid      = 1'b0;
        rd_data       = '0;
        rd_last       = 1'b0;

        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    cnt_load  = 1'b1;
                    err_clr   = 1'b1;
                    state_nxt = cmd_write ? ST_AW : ST_AR;
                end
            end
            ST_AW: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) begin
                    state_nxt = ST_W;
                end
            end
            ST_W: begin
                m_axi_wvalid = wr_valid;
                wr_ready     = m_axi_wready;
                m_axi_wdata  = wr_data;
                m_axi_wstrb  = '1;
                m_axi_wlast  = is_last;
                if (wr_valid && m_axi_wready) begin
                    if (is_last) begin
                        state_nxt = ST_B;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ST_B: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    err_set   = (m_axi_bresp != RESP_OKAY);
                    state_nxt = ST_DONE;
                end
            end
            ST_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_nxt = ST_R;
                end
            end
            ST_R: begin
                m_axi_rready = rd_ready;
                rd_valid     = m_axi_rvalid;
                rd_data      = m_axi_rdata;
                rd_last      = is_last;
                // Beat count, not rlast, decides where the burst ends.
                if (m_axi_rvalid && rd_ready) begin
                    err_set = (m_axi_rresp != RESP_OKAY) || (m_axi_rlast != is_last);
                    if (is_last) begin
                        state_nxt = ST_DONE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master against a behavioural AXI SRAM slave.
module tb_axi_burst_master;

    logic        clk, rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready, rd_last;
    logic        done, err;
    logic [3:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
    logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic [2:0]  m_axi_awsize, m_axi_arsize;
    logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
    logic        m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    int total = 0;
    int bad   = 0;

    axi_burst_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_last(rd_last),
        .done(done), .err(err),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave configuration, written only by the stimulus process.
    int          aw_delay = 1, ar_delay = 1, early_last = -1;
    bit          w_rand = 1'b0, mon_clear = 1'b0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    // Slave/monitor state, written only by the slave process.
    logic [31:0] mem [0:511];
    logic [31:0] rd_got [0:511];
    logic        rd_last_got [0:511];
    logic [31:0] w_ptr, r_ptr, aw_addr_s, ar_addr_s, aw_hold_addr, ar_hold_addr;
    logic [7:0]  aw_len_s, ar_len_s, aw_hold_len, ar_hold_len;
    logic [8:0]  aw_fix_s, ar_fix_s;
    int          aw_wait, ar_wait, r_left, r_idx, cyc;
    int          w_beats, r_beats, done_n, aw_n, ar_n, wlast_n, wlast_idx, rd_last_n;
    int          strb_bad, unstable, fin_cyc, done_cyc, rdy_cyc;
    bit          b_pend, r_act, aw_hold, ar_hold, prev_rdy;

    initial begin
        cyc = 0; b_pend = 0; r_act = 0; aw_hold = 0; ar_hold = 0; prev_rdy = 0;
        aw_wait = 0; ar_wait = 0; r_left = 0; r_idx = 0; w_ptr = 0; r_ptr = 0;
    end

    // Drive slave outputs on the falling edge, then log what the next rising edge will accept.
    always @(negedge clk) begin
        if (rst) begin
            m_axi_awready = 0; m_axi_arready = 0; m_axi_wready = 0;
            m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_bid = 0;
            m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0; m_axi_rlast = 0; m_axi_rid = 0;
        end else begin
            m_axi_awready = m_axi_awvalid && (aw_wait >= aw_delay);
            m_axi_arready = m_axi_arvalid && (ar_wait >= ar_delay);
            m_axi_wready  = w_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            m_axi_bvalid  = b_pend;
            m_axi_bresp   = b_pend ? bresp_cfg : 2'b00;
            m_axi_bid     = 4'd0;
            m_axi_rvalid  = r_act;
            m_axi_rdata   = r_act ? mem[r_ptr[10:2]] : 32'h0;
            m_axi_rresp   = r_act ? rresp_cfg : 2'b00;
            m_axi_rlast   = r_act && ((early_last >= 0) ? (r_idx == early_last) : (r_left == 1));
            m_axi_rid     = 4'd0;
        end
        #1;
        cyc++;
        if (mon_clear) begin
            w_beats = 0; r_beats = 0; done_n = 0; aw_n = 0; ar_n = 0; wlast_n = 0;
            wlast_idx = -1; rd_last_n = 0; strb_bad = 0; unstable = 0;
            fin_cyc = 0; done_cyc = 0; rdy_cyc = 0;
        end
        if (rst) begin
            aw_wait = 0; ar_wait = 0; b_pend = 0; r_act = 0; aw_hold = 0; ar_hold = 0;
        end else begin
            if (aw_hold && (!m_axi_awvalid || m_axi_awaddr !== aw_hold_addr || m_axi_awlen !== aw_hold_len))
                unstable++;
            if (ar_hold && (!m_axi_arvalid || m_axi_araddr !== ar_hold_addr || m_axi_arlen !== ar_hold_len))
                unstable++;
            aw_hold = m_axi_awvalid && !m_axi_awready;
            ar_hold = m_axi_arvalid && !m_axi_arready;
            aw_hold_addr = m_axi_awaddr; aw_hold_len = m_axi_awlen;
            ar_hold_addr = m_axi_araddr; ar_hold_len = m_axi_arlen;
            if (m_axi_awvalid) begin
                if (m_axi_awready) begin
                    aw_n++; aw_addr_s = m_axi_awaddr; aw_len_s = m_axi_awlen;
                    aw_fix_s = {m_axi_awid, m_axi_awsize, m_axi_awburst};
                    w_ptr = m_axi_awaddr; aw_wait = 0;
                end else aw_wait++;
            end
            if (m_axi_bvalid && m_axi_bready) begin
                b_pend = 0; fin_cyc = cyc;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                mem[w_ptr[10:2]] = m_axi_wdata;
                if (m_axi_wstrb !== 4'hF) strb_bad++;
                if (m_axi_wlast) begin
                    wlast_n++; wlast_idx = w_beats; b_pend = 1;
                end
                w_beats++; w_ptr = w_ptr + 32'd4;
            end
            if (rd_valid && rd_ready && r_beats < 512) begin
                rd_got[r_beats] = rd_data; rd_last_got[r_beats] = rd_last;
                if (rd_last) begin
                    rd_last_n++; fin_cyc = cyc;
                end
                r_beats++;
            end
            if (m_axi_rvalid && m_axi_rready) begin
                r_idx++; r_left--; r_ptr = r_ptr + 32'd4;
                if (r_left == 0) r_act = 0;
            end
            if (m_axi_arvalid) begin
                if (m_axi_arready) begin
                    ar_n++; ar_addr_s = m_axi_araddr; ar_len_s = m_axi_arlen;
                    ar_fix_s = {m_axi_arid, m_axi_arsize, m_axi_arburst};
                    r_ptr = m_axi_araddr; r_left = int'(m_axi_arlen) + 1; r_idx = 0;
                    r_act = 1; ar_wait = 0;
                end else ar_wait++;
            end
            if (done) begin
                done_n++; done_cyc = cyc;
            end
            if (cmd_ready && !prev_rdy) rdy_cyc = cyc;
        end
        prev_rdy = cmd_ready;
    end

    // Stimulus-side observations.
    logic        first_valid, err_at_accept;
    int          stall_valid_n, stall_chg;
    logic [31:0] stall_data;

    task automatic clear_mon();
        @(negedge clk);
        mon_clear = 1'b1;
        #2;
        mon_clear = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        wr_data = 0; wr_valid = 0; rd_ready = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [7:0] l);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
        @(negedge clk);
        cmd_valid = 1'b0;
        #2;
        first_valid   = w ? m_axi_awvalid : m_axi_arvalid;
        err_at_accept = err;
    endtask

    task automatic run_write(input logic [31:0] a, input logic [7:0] l,
                             input logic [31:0] base, input bit gaps, output bit ok);
        int idx = 0;
        ok = 1'b0;
        issue_cmd(1'b1, a, l);
        for (int c = 0; c < 3000; c++) begin
            if (idx <= int'(l)) begin
                wr_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                wr_data  = base + 32'(idx);
            end else wr_valid = 1'b0;
            #2;
            if (wr_valid && wr_ready) idx++;
            if (done_n > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
    endtask

    task automatic run_read(input logic [31:0] a, input logic [7:0] l,
                            input int stall_at, output bit ok);
        int stall = 0;
        ok = 1'b0; stall_valid_n = 0; stall_chg = 0;
        issue_cmd(1'b0, a, l);
        for (int c = 0; c < 3000; c++) begin
            if (stall_at >= 0 && r_beats == stall_at && stall < 5) begin
                rd_ready = 1'b0;
                #2;
                if (rd_valid) stall_valid_n++;
                if (stall > 0 && rd_data !== stall_data) stall_chg++;
                stall_data = rd_data;
                stall++;
            end else begin
                rd_ready = 1'b1;
                #2;
            end
            if (done_n > 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({cmd_ready, done, err, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, rd_valid,
             m_axi_bready, m_axi_rready, m_axi_wlast, rd_last} !== 11'b100_0000_0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=%b", {cmd_ready, done, err, m_axi_awvalid,
                     m_axi_wvalid, m_axi_arvalid, rd_valid, m_axi_bready, m_axi_rready,
                     m_axi_wlast, rd_last}, 11'b100_0000_0000);
        end
        total++;
        if ({m_axi_awaddr, m_axi_araddr, m_axi_wdata, rd_data, m_axi_awlen, m_axi_arlen} !== 144'h0) begin
            bad++;
            $display("FAIL reset_payload awaddr=%h araddr=%h wdata=%h rd_data=%h want all zero",
                     m_axi_awaddr, m_axi_araddr, m_axi_wdata, rd_data);
        end
    endtask

    task automatic test_write();
        bit ok;
        clear_mon();
        aw_delay = 2; w_rand = 1'b0; bresp_cfg = 2'b00;
        run_write(32'h10, 8'd3, 32'hA0, 1'b0, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL write_timeout done_n=%0d want 1", done_n); end
        total++;
        if (first_valid !== 1'b1) begin bad++; $display("FAIL write_aw_latency awvalid=%b want 1", first_valid); end
        total++;
        if (cmd_ready !== 1'b0) begin bad++; $display("FAIL write_ready_early cmd_ready=%b want 0", cmd_ready); end
        @(negedge clk); #2;
        total++;
        if ({aw_n, aw_addr_s, aw_len_s, aw_fix_s} !== {32'd1, 32'h10, 8'd3, 9'b0000_010_01}) begin
            bad++;
            $display("FAIL write_aw n=%0d addr=%h len=%0d fix=%b want 1 10 3 000001001",
                     aw_n, aw_addr_s, aw_len_s, aw_fix_s);
        end
        total++;
        if (w_beats != 4 || wlast_n != 1 || wlast_idx != 3 || strb_bad != 0) begin
            bad++;
            $display("FAIL write_beats beats=%0d wlast_n=%0d wlast_idx=%0d strb_bad=%0d want 4 1 3 0",
                     w_beats, wlast_n, wlast_idx, strb_bad);
        end
        total++;
        if ({mem[4], mem[5], mem[6], mem[7]} !== {32'hA0, 32'hA1, 32'hA2, 32'hA3}) begin
            bad++;
            $display("FAIL write_mem got=%h %h %h %h want a0 a1 a2 a3", mem[4], mem[5], mem[6], mem[7]);
        end
        total++;
        if (done_n != 1 || done_cyc != fin_cyc + 1 || rdy_cyc != fin_cyc + 2 || err !== 1'b0) begin
            bad++;
            $display("FAIL write_done done_n=%0d done_at=%0d ready_at=%0d b_at=%0d err=%b want 1 b+1 b+2 0",
                     done_n, done_cyc, rdy_cyc, fin_cyc, err);
        end
    endtask

    task automatic test_read();
        bit ok;
        clear_mon();
        ar_delay = 1; rresp_cfg = 2'b00; early_last = -1;
        run_read(32'h10, 8'd3, -1, ok);
        @(negedge clk); #2;
        total++;
        if (!ok || first_valid !== 1'b1) begin
            bad++; $display("FAIL read_start ok=%b arvalid=%b want 1 1", ok, first_valid);
        end
        total++;
        if (r_beats != 4 || {rd_got[0], rd_got[1], rd_got[2], rd_got[3]} !== {32'hA0, 32'hA1, 32'hA2, 32'hA3}) begin
            bad++;
            $display("FAIL read_data beats=%0d got=%h %h %h %h want 4 a0 a1 a2 a3",
                     r_beats, rd_got[0], rd_got[1], rd_got[2], rd_got[3]);
        end
        total++;
        if ({rd_last_got[0], rd_last_got[1], rd_last_got[2], rd_last_got[3]} !== 4'b0001) begin
            bad++;
            $display("FAIL read_last got=%b want 0001",
                     {rd_last_got[0], rd_last_got[1], rd_last_got[2], rd_last_got[3]});
        end
        total++;
        if (done_n != 1 || done_cyc != fin_cyc + 1 || rdy_cyc != fin_cyc + 2 || err !== 1'b0 ||
            ar_addr_s !== 32'h10 || ar_fix_s !== 9'b0000_010_01) begin
            bad++;
            $display("FAIL read_done done_n=%0d done_at=%0d ready_at=%0d r_at=%0d err=%b araddr=%h",
                     done_n, done_cyc, rdy_cyc, fin_cyc, err, ar_addr_s);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int mis = 0;
        clear_mon();
        aw_delay = 3; ar_delay = 3; w_rand = 1'b1;
        run_write(32'h40, 8'd7, 32'hB0, 1'b1, ok);
        w_rand = 1'b0;
        @(negedge clk);
        total++;
        if (!ok || w_beats != 8 || wlast_idx != 7 || unstable != 0) begin
            bad++;
            $display("FAIL bp_write ok=%b beats=%0d wlast_idx=%0d unstable=%0d want 1 8 7 0",
                     ok, w_beats, wlast_idx, unstable);
        end
        clear_mon();
        run_read(32'h40, 8'd7, 3, ok);
        @(negedge clk); #2;
        for (int i = 0; i < 8; i++) if (rd_got[i] !== 32'hB0 + 32'(i)) mis++;
        total++;
        if (!ok || r_beats != 8 || mis != 0 || unstable != 0) begin
            bad++;
            $display("FAIL bp_read ok=%b beats=%0d mismatches=%0d unstable=%0d want 1 8 0 0",
                     ok, r_beats, mis, unstable);
        end
        total++;
        if (stall_valid_n != 5 || stall_chg != 0 || stall_data !== 32'hB3) begin
            bad++;
            $display("FAIL bp_stall valid_cycles=%0d changes=%0d data=%h want 5 0 b3",
                     stall_valid_n, stall_chg, stall_data);
        end
        aw_delay = 1; ar_delay = 1;
    endtask

    task automatic test_single_max();
        bit ok_w, ok_r;
        int mis = 0;
        clear_mon();
        run_write(32'h80, 8'd0, 32'hC0, 1'b0, ok_w);
        @(negedge clk);
        total++;
        if (!ok_w || w_beats != 1 || wlast_idx != 0 || mem[32] !== 32'hC0) begin
            bad++;
            $display("FAIL single_write ok=%b beats=%0d wlast_idx=%0d mem=%h want 1 1 0 c0",
                     ok_w, w_beats, wlast_idx, mem[32]);
        end
        clear_mon();
        run_read(32'h80, 8'd0, -1, ok_r);
        @(negedge clk); #2;
        total++;
        if (!ok_r || r_beats != 1 || rd_got[0] !== 32'hC0 || rd_last_got[0] !== 1'b1) begin
            bad++;
            $display("FAIL single_read ok=%b beats=%0d data=%h last=%b want 1 1 c0 1",
                     ok_r, r_beats, rd_got[0], rd_last_got[0]);
        end
        clear_mon();
        run_write(32'h100, 8'd255, 32'h1000, 1'b0, ok_w);
        @(negedge clk);
        total++;
        if (!ok_w || w_beats != 256 || wlast_n != 1 || wlast_idx != 255 || done_n != 1) begin
            bad++;
            $display("FAIL max_write ok=%b beats=%0d wlast_n=%0d wlast_idx=%0d done_n=%0d want 1 256 1 255 1",
                     ok_w, w_beats, wlast_n, wlast_idx, done_n);
        end
        clear_mon();
        run_read(32'h100, 8'd255, -1, ok_r);
        @(negedge clk); #2;
        for (int i = 0; i < 256; i++) if (rd_got[i] !== 32'h1000 + 32'(i)) mis++;
        total++;
        if (!ok_r || r_beats != 256 || mis != 0 || rd_last_n != 1 || rd_last_got[255] !== 1'b1 ||
            err !== 1'b0) begin
            bad++;
            $display("FAIL max_read ok=%b beats=%0d mismatches=%0d last_n=%0d err=%b want 1 256 0 1 0",
                     ok_r, r_beats, mis, rd_last_n, err);
        end
    endtask

    task automatic test_errors();
        bit ok;
        clear_mon();
        bresp_cfg = 2'b10;
        run_write(32'h200, 8'd0, 32'hD0, 1'b0, ok);
        bresp_cfg = 2'b00;
        repeat (3) @(negedge clk);
        total++;
        if (!ok || err !== 1'b1) begin bad++; $display("FAIL bresp_err ok=%b err=%b want 1 1", ok, err); end
        clear_mon();
        early_last = 1;
        run_read(32'h10, 8'd3, -1, ok);
        early_last = -1;
        @(negedge clk); #2;
        total++;
        if (err_at_accept !== 1'b0) begin bad++; $display("FAIL err_clear_accept err=%b want 0", err_at_accept); end
        total++;
        if (!ok || err !== 1'b1 || r_beats != 4 || rd_got[3] !== 32'hA3 || rd_last_got[3] !== 1'b1) begin
            bad++;
            $display("FAIL early_rlast ok=%b err=%b beats=%0d last_data=%h last=%b want 1 1 4 a3 1",
                     ok, err, r_beats, rd_got[3], rd_last_got[3]);
        end
        clear_mon();
        rresp_cfg = 2'b10;
        run_read(32'h10, 8'd1, -1, ok);
        rresp_cfg = 2'b00;
        @(negedge clk); #2;
        total++;
        if (!ok || err_at_accept !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL rresp_err ok=%b err_at_accept=%b err=%b want 1 0 1", ok, err_at_accept, err);
        end
        clear_mon();
        run_read(32'h10, 8'd0, -1, ok);
        @(negedge clk); #2;
        total++;
        if (!ok || err !== 1'b0 || rd_got[0] !== 32'hA0) begin
            bad++; $display("FAIL clean_after_err ok=%b err=%b data=%h want 1 0 a0", ok, err, rd_got[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok = 1'b0;
        clear_mon();
        issue_cmd(1'b0, 32'h10, 8'd3);
        for (int c = 0; c < 50; c++) begin
            rd_ready = 1'b1;
            #2;
            if (r_beats == 1 && rd_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin bad++; $display("FAIL midreset_reach beats=%0d want 1", r_beats); end
        rst = 1'b1;
        #1;
        total++;
        if ({m_axi_rready, m_axi_arvalid, rd_valid, done} !== 4'b0000) begin
            bad++;
            $display("FAIL midreset_drop rready=%b arvalid=%b rd_valid=%b done=%b want 0000",
                     m_axi_rready, m_axi_arvalid, rd_valid, done);
        end
        rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        total++;
        if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready cmd_ready=%b want 1", cmd_ready); end
        clear_mon();
        run_read(32'h10, 8'd3, -1, ok);
        @(negedge clk); #2;
        total++;
        if (!ok || r_beats != 4 || {rd_got[0], rd_got[3]} !== {32'hA0, 32'hA3} || err !== 1'b0 || done_n != 1) begin
            bad++;
            $display("FAIL midreset_fresh ok=%b beats=%0d first=%h last=%h err=%b done_n=%0d want 1 4 a0 a3 0 1",
                     ok, r_beats, rd_got[0], rd_got[3], err, done_n);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_single_max();
        test_errors();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
